instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Full fetch/execute sequencer for the 8-bit mini computer datapath. It drives every register enable and set strobe, the bus-1 constant, the ALU opcode and carry-in, and holds the CPU flag register. Each instruction runs as six steps, and each step takes two clock cycles. An instruction-boundary hold handshake lets a debugger or loader park the CPU.

## Interface
Parameters: none.

Ports:
- `clk` input, 1 bit. System clock; all state changes on the rising edge.
- `rst` input, 1 bit. Asynchronous, active-high reset.
- `ir` input, 8 bits. Instruction register contents; valid from step 3 onward.
- `alu_flags` input, 4 bits. ALU flag outputs {C,A,E,Z} (bit 3 = C, bit 0 = Z).
- `hold` input, 1 bit. Request to park at the next instruction boundary.
- `held` output, 1 bit. High while parked in IDLE.
- `reg_en` output, 4 bits. One-hot enable of R0–R3 onto the bus.
- `reg_set` output, 4 bits. One-hot set strobe for R0–R3.
- `ram_en`, `acc_en`, `iar_en` outputs, 1 bit each. Bus enables.
- `ir_set`, `mar_set`, `acc_set`, `ram_set`, `tmp_set`, `iar_set` outputs, 1 bit each. Set strobes.
- `b1` output, 1 bit. Forces the bus-1 constant into the ALU B input.
- `op` output, 3 bits. ALU opcode.
- `carry_in` output, 1 bit. ALU carry input.
- `flags` output, 4 bits. Flag register {C,A,E,Z}.

## Operation
- **States.** The FSM has an IDLE state plus (step 1..6, phase E/S).
  - Phase E drives enables only.
  - Phase S keeps the same enables and adds the set strobes for that step.
  - `op` and `b1` follow the enables and are valid in both phases.
  - All signals not listed for a step are 0. `op` defaults to 000 (ADD).
- **Fetch.**
  - Step 1: `iar_en`, `b1`, `mar_set`, `acc_set`.
  - Step 2: `ram_en`, `ir_set`.
  - Step 3: `acc_en`, `iar_set`.
- **Execute.** RA = `ir[3:2]`, RB = `ir[1:0]`, decoded one-hot onto `reg_en`/`reg_set`.
  - **ALU (ir[7]=1), op = ir[6:4].**
    - Step 4: `reg_en`[RB], `tmp_set`.
    - Step 5: `reg_en`[RA], `op`, `carry_in` = `flags`[3], `acc_set`, flag load.
    - Step 6: `acc_en`, `reg_set`[RB]; `reg_set` is suppressed when op = 111 (CMP).
  - **LD (0000).**
    - Step 4: `reg_en`[RA], `mar_set`.
    - Step 5: `ram_en`, `reg_set`[RB].
  - **ST (0001).**
    - Step 4: `reg_en`[RA], `mar_set`.
    - Step 5: `reg_en`[RB], `ram_set`.
  - **DATA (0010).**
    - Step 4: `iar_en`, `b1`, `mar_set`, `acc_set`.
    - Step 5: `ram_en`, `reg_set`[RB].
    - Step 6: `acc_en`, `iar_set`.
  - **JMPR (0011).**
    - Step 4: `reg_en`[RB], `iar_set`.
  - **JMP (0100).**
    - Step 4: `iar_en`, `mar_set`.
    - Step 5: `ram_en`, `iar_set`.
  - **JCAEZ (0101), mask = ir[3:0].**
    - Step 4: `iar_en`, `b1`, `mar_set`, `acc_set`.
    - Step 5: `acc_en`, `iar_set`.
    - Step 6: if (`ir[3:0]` & `flags`) != 0, drive `ram_en` and `iar_set`; otherwise nothing.
  - **CLF (0110).** Clear `flags` to 0 at the rising edge that ends step 4 S.
  - **0111.** Reserved; steps 4–6 are idle (NOP).
- **Flag register.**
  - Loads `alu_flags` at the edge ending step 5 S of ALU instructions only, CMP included.
  - The fetch-step ADD (step 1) and the step-4 increments of DATA and JCAEZ never update flags.
  - JCAEZ tests the flag value that existed before the instruction.
- **Hold handshake.**
  - `hold` is sampled at the edge ending step 6 S, and at every edge while in IDLE.
  - At step 6 S: if `hold`=1, go to IDLE; otherwise go to step 1 E.
  - In IDLE: when `hold`=0, go to step 1 E; `held` falls on that edge.
  - `hold` is never honoured mid-instruction.
- **Reset.**
  - Asserting `rst` forces IDLE immediately and asynchronously, including mid-instruction.
  - All strobes drop in the same cycle, with no partial set pulse.
  - `flags` are cleared.

## Timing
- **Reset values.** All enables, sets, `b1`, `op` and `carry_in` = 0; `flags` = 0000; `held` = 1.
- **First fetch.** After `rst` deasserts with `hold`=0, IDLE lasts 1 cycle; step 1 E is the next cycle.
- **Instruction length.** Every instruction takes exactly 12 cycles, whether or not later steps are empty.
  - The next instruction's step 1 E immediately follows step 6 S; there are no bubbles.
- **Set strobes.**
  - Each set strobe is high for exactly one cycle (the S phase).
  - Each enable is high for 2 cycles (E+S).
- **Output encoding.** All outputs decode combinationally from registered state plus `ir`/`flags`, so there is no extra latency.
  - `ir` changes only at the step-2 S edge. Execute decode is therefore stable throughout steps 4–6.

## Test plan
- **Reset and first fetch.** Assert `rst` mid-step-5 of an ST. Required: `ram_set` drops immediately, `held`=1, `flags`=0. Release `rst` with `hold`=0: `iar_en`=`b1`=1 one cycle later, and `mar_set`/`acc_set` pulse on cycle 2 only.
- **ALU and CMP.** `ir`=8'b1000_0110 (ADD R1,R2), `alu_flags`=4'b1001. Required: `tmp_set` with `reg_en`=0100 at step 4; `op`=000 with `reg_en`=0010 at step 5; `flags`=1001 after step 5; `reg_set`=0100 at step 6. Repeat with `ir`=8'hF6 (CMP): `reg_set` stays 0 in all 12 cycles.
- **LD / ST / DATA.** For each, check `mar_set` and `reg_set`/`ram_set` one-hots against RA and RB, e.g. LD R3←[R0] with `ir`=8'h03: `reg_en`=0001, then `reg_set`=1000. For DATA, `iar_set` pulses in step 6.
- **JCAEZ taken and not taken.**
  - `flags`=0001, `ir`=8'h51 (JZ): `ram_en`+`iar_set` in step 6.
  - `ir`=8'h58 (JC): step 6 is empty.
  - A CLF (`ir`=8'h60) followed by JZ is not taken.
- **Hold handshake.**
  - Raise `hold` in step 3: the instruction completes all 12 cycles, then `held`=1 and all strobes are 0.
  - Drop `hold`: step 1 E appears on the next cycle.
  - With `hold` held high continuously, the sequencer stays in IDLE indefinitely.
- **Back-to-back flow.** Run 4 consecutive instructions. Required: exactly 48 cycles with no idle cycle between them, and exactly one `ir_set` per 12 cycles.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Fetch/execute sequencer for the 8-bit mini computer: six two-phase steps per instruction,
// register/bus strobes, ALU control, flag register and an instruction-boundary hold handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | parked at an instruction boundary (held = 1)
//   nE      | step n (1..6), enable phase: enables, op, b1 only
//   nS      | step n (1..6), set phase: same enables plus set strobes
module instruction_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic [3:0] alu_flags,
    input  logic       hold,
    output logic       held,
    output logic [3:0] reg_en,
    output logic [3:0] reg_set,
    output logic       ram_en,
    output logic       acc_en,
    output logic       iar_en,
    output logic       ir_set,
    output logic       mar_set,
    output logic       acc_set,
    output logic       ram_set,
    output logic       tmp_set,
    output logic       iar_set,
    output logic       b1,
    output logic [2:0] op,
    output logic       carry_in,
    output logic [3:0] flags
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_1E, ST_1S, ST_2E, ST_2S, ST_3E, ST_3S,
        ST_4E, ST_4S, ST_5E, ST_5S, ST_6E, ST_6S
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] step;
    logic       ph_s;
    logic [3:0] ra_oh;
    logic [3:0] rb_oh;
    logic [3:0] s_reg;
    logic       s_ir, s_mar, s_acc, s_ram, s_tmp, s_iar;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_6S: state_nxt = hold ? ST_IDLE : ST_1E;
            default:        state_nxt = state_t'(state + 4'd1);
        endcase
    end

    // Flags only move on ALU step 5 S or a CLF step 4 S, so JCAEZ sees the pre-instruction value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags <= 4'b0000;
        else if (state == ST_5S && ir[7])
            flags <= alu_flags;
        else if (state == ST_4S && ir[7:4] == 4'b0110)
            flags <= 4'b0000;
    end

    assign step  = 3'((state + 4'd1) >> 1);
    assign ph_s  = (state != ST_IDLE) && !state[0];
    assign ra_oh = 4'b0001 << ir[3:2];
    assign rb_oh = 4'b0001 << ir[1:0];
    assign held  = (state == ST_IDLE);

    always_comb begin
        reg_en   = 4'b0000;
        ram_en   = 1'b0;
        acc_en   = 1'b0;
        iar_en   = 1'b0;
        b1       = 1'b0;
        op       = 3'b000;
        carry_in = 1'b0;
        s_reg    = 4'b0000;
        s_ir     = 1'b0;
        s_mar    = 1'b0;
        s_acc    = 1'b0;
        s_ram    = 1'b0;
        s_tmp    = 1'b0;
        s_iar    = 1'b0;
        case (step)
            3'd1: begin iar_en = 1'b1; b1 = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
            3'd2: begin ram_en = 1'b1; s_ir = 1'b1; end
            3'd3: begin acc_en = 1'b1; s_iar = 1'b1; end
            3'd4, 3'd5, 3'd6: begin
                if (ir[7]) begin
                    case (step)
                        3'd4: begin reg_en = rb_oh; s_tmp = 1'b1; end
                        3'd5: begin
                            reg_en   = ra_oh;
                            op       = ir[6:4];
                            carry_in = flags[3];
                            s_acc    = 1'b1;
                        end
                        default: begin
                            acc_en = 1'b1;
                            if (ir[6:4] != 3'b111)
                                s_reg = rb_oh;
                        end
                    endcase
                end else begin
                    case ({ir[6:4], step})
                        {3'b000, 3'd4}: begin reg_en = ra_oh; s_mar = 1'b1; end
                        {3'b000, 3'd5}: begin ram_en = 1'b1; s_reg = rb_oh; end
                        {3'b001, 3'd4}: begin reg_en = ra_oh; s_mar = 1'b1; end
                        {3'b001, 3'd5}: begin reg_en = rb_oh; s_ram = 1'b1; end
                        {3'b010, 3'd4}: begin iar_en = 1'b1; b1 = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
                        {3'b010, 3'd5}: begin ram_en = 1'b1; s_reg = rb_oh; end
                        {3'b010, 3'd6}: begin acc_en = 1'b1; s_iar = 1'b1; end
                        {3'b011, 3'd4}: begin reg_en = rb_oh; s_iar = 1'b1; end
                        {3'b100, 3'd4}: begin iar_en = 1'b1; s_mar = 1'b1; end
                        {3'b100, 3'd5}: begin ram_en = 1'b1; s_iar = 1'b1; end
                        {3'b101, 3'd4}: begin iar_en = 1'b1; b1 = 1'b1; s_mar = 1'b1; s_acc = 1'b1; end
                        {3'b101, 3'd5}: begin acc_en = 1'b1; s_iar = 1'b1; end
                        {3'b101, 3'd6}: begin
                            if ((ir[3:0] & flags) != 4'b0000) begin
                                ram_en = 1'b1;
                                s_iar  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        // Set strobes exist only in the S phase; enables span both phases.
        reg_set = ph_s ? s_reg : 4'b0000;
        ir_set  = ph_s & s_ir;
        mar_set = ph_s & s_mar;
        acc_set = ph_s & s_acc;
        ram_set = ph_s & s_ram;
        tmp_set = ph_s & s_tmp;
        iar_set = ph_s & s_iar;
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed testbench for instruction_sequencer: records each 12-cycle instruction and compares
// the per-cycle strobe patterns against hand-derived values.
module tb_instruction_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] ir;
    logic [3:0] alu_flags;
    logic       hold;
    logic       held;
    logic [3:0] reg_en, reg_set;
    logic       ram_en, acc_en, iar_en;
    logic       ir_set, mar_set, acc_set, ram_set, tmp_set, iar_set;
    logic       b1;
    logic [2:0] op;
    logic       carry_in;
    logic [3:0] flags;
    logic [21:0] all_out;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0]  r_reg_en  [12];
    logic [3:0]  r_reg_set [12];
    logic [2:0]  r_op      [12];
    logic [3:0]  r_flags   [12];
    logic [11:0] r_ram_en, r_acc_en, r_iar_en, r_ir_set, r_mar_set, r_acc_set;
    logic [11:0] r_ram_set, r_tmp_set, r_iar_set, r_b1, r_cin, r_held;

    instruction_sequencer dut (
        .clk(clk), .rst(rst), .ir(ir), .alu_flags(alu_flags), .hold(hold), .held(held),
        .reg_en(reg_en), .reg_set(reg_set), .ram_en(ram_en), .acc_en(acc_en), .iar_en(iar_en),
        .ir_set(ir_set), .mar_set(mar_set), .acc_set(acc_set), .ram_set(ram_set),
        .tmp_set(tmp_set), .iar_set(iar_set), .b1(b1), .op(op), .carry_in(carry_in),
        .flags(flags)
    );

    assign all_out = {reg_en, reg_set, ram_en, acc_en, iar_en, ir_set, mar_set, acc_set,
                      ram_set, tmp_set, iar_set, b1, op, carry_in};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Entered at the negedge of step 1 E; leaves at the negedge following step 6 S.
    task automatic run_instr(input logic [7:0] v, input logic raise_hold);
        for (int c = 0; c < 12; c++) begin
            r_reg_en[c]  = reg_en;
            r_reg_set[c] = reg_set;
            r_op[c]      = op;
            r_flags[c]   = flags;
            r_ram_en[c]  = ram_en;
            r_acc_en[c]  = acc_en;
            r_iar_en[c]  = iar_en;
            r_ir_set[c]  = ir_set;
            r_mar_set[c] = mar_set;
            r_acc_set[c] = acc_set;
            r_ram_set[c] = ram_set;
            r_tmp_set[c] = tmp_set;
            r_iar_set[c] = iar_set;
            r_b1[c]      = b1;
            r_cin[c]     = carry_in;
            r_held[c]    = held;
            if (c == 3) ir = v;
            if (c == 4 && raise_hold) hold = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; hold = 1'b0; ir = 8'h70; alu_flags = 4'b0000;
        repeat (2) @(negedge clk);
        vectors++; if (all_out !== 22'd0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL reset_held: got %b expected 1", held); end
        vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    endtask

    task automatic test_first_fetch;
        rst = 1'b0;
        vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL idle_after_reset: held got %b expected 1", held); end
        @(negedge clk);
        run_instr(8'h70, 1'b0);
        vectors++; if (r_iar_en !== 12'b0000_0000_0011) begin miscompares++; $display("FAIL fetch_iar_en: got %b expected 000000000011", r_iar_en); end
        vectors++; if (r_b1 !== 12'b0000_0000_0011) begin miscompares++; $display("FAIL fetch_b1: got %b expected 000000000011", r_b1); end
        vectors++; if (r_mar_set !== 12'b0000_0000_0010) begin miscompares++; $display("FAIL fetch_mar_set: got %b expected 000000000010", r_mar_set); end
        vectors++; if (r_acc_set !== 12'b0000_0000_0010) begin miscompares++; $display("FAIL fetch_acc_set: got %b expected 000000000010", r_acc_set); end
        vectors++; if (r_ram_en !== 12'b0000_0000_1100) begin miscompares++; $display("FAIL fetch_ram_en: got %b expected 000000001100", r_ram_en); end
        vectors++; if (r_ir_set !== 12'b0000_0000_1000) begin miscompares++; $display("FAIL fetch_ir_set: got %b expected 000000001000", r_ir_set); end
        vectors++; if (r_iar_set !== 12'b0000_0010_0000) begin miscompares++; $display("FAIL fetch_iar_set: got %b expected 000000100000", r_iar_set); end
        vectors++; if (r_held !== 12'b0) begin miscompares++; $display("FAIL fetch_held: got %b expected 0", r_held); end
    endtask

    task automatic test_alu_cmp;
        logic [3:0] any_set;
        alu_flags = 4'b1001;
        run_instr(8'b1000_0110, 1'b0);
        vectors++; if (r_tmp_set !== 12'b0000_1000_0000) begin miscompares++; $display("FAIL add_tmp_set: got %b expected 000010000000", r_tmp_set); end
        vectors++; if (r_reg_en[6] !== 4'b0100) begin miscompares++; $display("FAIL add_step4_reg_en: got %b expected 0100", r_reg_en[6]); end
        vectors++; if (r_reg_en[8] !== 4'b0010) begin miscompares++; $display("FAIL add_step5_reg_en: got %b expected 0010", r_reg_en[8]); end
        vectors++; if (r_op[8] !== 3'b000) begin miscompares++; $display("FAIL add_op: got %b expected 000", r_op[8]); end
        vectors++; if (r_acc_set !== 12'b0010_0000_0010) begin miscompares++; $display("FAIL add_acc_set: got %b expected 001000000010", r_acc_set); end
        vectors++; if (r_cin !== 12'b0) begin miscompares++; $display("FAIL add_carry_in: got %b expected 0", r_cin); end
        vectors++; if (r_flags[9] !== 4'b0000) begin miscompares++; $display("FAIL add_flags_before: got %b expected 0000", r_flags[9]); end
        vectors++; if (r_flags[10] !== 4'b1001) begin miscompares++; $display("FAIL add_flags_after: got %b expected 1001", r_flags[10]); end
        vectors++; if (r_reg_set[10] !== 4'b0000) begin miscompares++; $display("FAIL add_reg_set_6e: got %b expected 0000", r_reg_set[10]); end
        vectors++; if (r_reg_set[11] !== 4'b0100) begin miscompares++; $display("FAIL add_reg_set_6s: got %b expected 0100", r_reg_set[11]); end
        vectors++; if (r_acc_en !== 12'b1100_0011_0000) begin miscompares++; $display("FAIL add_acc_en: got %b expected 110000110000", r_acc_en); end

        alu_flags = 4'b0011;
        run_instr(8'hF6, 1'b0);
        any_set = 4'b0000;
        for (int c = 0; c < 12; c++) any_set = any_set | r_reg_set[c];
        vectors++; if (any_set !== 4'b0000) begin miscompares++; $display("FAIL cmp_reg_set: got %b expected 0000", any_set); end
        vectors++; if (r_op[8] !== 3'b111 || r_op[9] !== 3'b111) begin miscompares++; $display("FAIL cmp_op: got %b/%b expected 111/111", r_op[8], r_op[9]); end
        vectors++; if (r_op[10] !== 3'b000) begin miscompares++; $display("FAIL cmp_op_step6: got %b expected 000", r_op[10]); end
        vectors++; if (r_cin !== 12'b0011_0000_0000) begin miscompares++; $display("FAIL cmp_carry_in: got %b expected 001100000000", r_cin); end
        vectors++; if (r_flags[10] !== 4'b0011) begin miscompares++; $display("FAIL cmp_flags: got %b expected 0011", r_flags[10]); end
    endtask

    task automatic test_ld_st_data;
        alu_flags = 4'b1111;
        run_instr(8'h03, 1'b0);
        vectors++; if (r_reg_en[6] !== 4'b0001 || r_reg_en[7] !== 4'b0001) begin miscompares++; $display("FAIL ld_reg_en: got %b/%b expected 0001/0001", r_reg_en[6], r_reg_en[7]); end
        vectors++; if (r_mar_set !== 12'b0000_1000_0010) begin miscompares++; $display("FAIL ld_mar_set: got %b expected 000010000010", r_mar_set); end
        vectors++; if (r_ram_en !== 12'b0011_0000_1100) begin miscompares++; $display("FAIL ld_ram_en: got %b expected 001100001100", r_ram_en); end
        vectors++; if (r_reg_set[8] !== 4'b0000 || r_reg_set[9] !== 4'b1000) begin miscompares++; $display("FAIL ld_reg_set: got %b/%b expected 0000/1000", r_reg_set[8], r_reg_set[9]); end

        run_instr(8'h1B, 1'b0);
        vectors++; if (r_reg_en[7] !== 4'b0100) begin miscompares++; $display("FAIL st_step4_reg_en: got %b expected 0100", r_reg_en[7]); end
        vectors++; if (r_reg_en[9] !== 4'b1000) begin miscompares++; $display("FAIL st_step5_reg_en: got %b expected 1000", r_reg_en[9]); end
        vectors++; if (r_ram_set !== 12'b0010_0000_0000) begin miscompares++; $display("FAIL st_ram_set: got %b expected 001000000000", r_ram_set); end
        vectors++; if (r_mar_set !== 12'b0000_1000_0010) begin miscompares++; $display("FAIL st_mar_set: got %b expected 000010000010", r_mar_set); end

        run_instr(8'h21, 1'b0);
        vectors++; if (r_reg_set[9] !== 4'b0010) begin miscompares++; $display("FAIL data_reg_set: got %b expected 0010", r_reg_set[9]); end
        vectors++; if (r_iar_set !== 12'b1000_0010_0000) begin miscompares++; $display("FAIL data_iar_set: got %b expected 100000100000", r_iar_set); end
        vectors++; if (r_b1 !== 12'b0000_1100_0011) begin miscompares++; $display("FAIL data_b1: got %b expected 000011000011", r_b1); end
        vectors++; if (r_acc_set !== 12'b0000_1000_0010) begin miscompares++; $display("FAIL data_acc_set: got %b expected 000010000010", r_acc_set); end
        vectors++; if (r_acc_en !== 12'b1100_0011_0000) begin miscompares++; $display("FAIL data_acc_en: got %b expected 110000110000", r_acc_en); end
        vectors++; if (r_flags[11] !== 4'b0011) begin miscompares++; $display("FAIL data_flags_kept: got %b expected 0011", r_flags[11]); end

        run_instr(8'h32, 1'b0);
        vectors++; if (r_reg_en[6] !== 4'b0100) begin miscompares++; $display("FAIL jmpr_reg_en: got %b expected 0100", r_reg_en[6]); end
        vectors++; if (r_iar_set !== 12'b0000_1010_0000) begin miscompares++; $display("FAIL jmpr_iar_set: got %b expected 000010100000", r_iar_set); end

        run_instr(8'h40, 1'b0);
        vectors++; if (r_iar_set !== 12'b0010_0010_0000) begin miscompares++; $display("FAIL jmp_iar_set: got %b expected 001000100000", r_iar_set); end
        vectors++; if (r_iar_en !== 12'b0000_1100_0011) begin miscompares++; $display("FAIL jmp_iar_en: got %b expected 000011000011", r_iar_en); end
    endtask

    task automatic test_jcaez;
        alu_flags = 4'b0001;
        run_instr(8'h80, 1'b0);
        vectors++; if (flags !== 4'b0001) begin miscompares++; $display("FAIL jz_setup_flags: got %b expected 0001", flags); end
        run_instr(8'h51, 1'b0);
        vectors++; if (r_ram_en !== 12'b1100_0000_1100) begin miscompares++; $display("FAIL jz_taken_ram_en: got %b expected 110000001100", r_ram_en); end
        vectors++; if (r_iar_set !== 12'b1010_0010_0000) begin miscompares++; $display("FAIL jz_taken_iar_set: got %b expected 101000100000", r_iar_set); end
        run_instr(8'h58, 1'b0);
        vectors++; if (r_ram_en !== 12'b0000_0000_1100) begin miscompares++; $display("FAIL jc_not_taken_ram_en: got %b expected 000000001100", r_ram_en); end
        vectors++; if (r_iar_set !== 12'b0010_0010_0000) begin miscompares++; $display("FAIL jc_not_taken_iar_set: got %b expected 001000100000", r_iar_set); end
        run_instr(8'h60, 1'b0);
        vectors++; if (r_flags[7] !== 4'b0001) begin miscompares++; $display("FAIL clf_flags_before: got %b expected 0001", r_flags[7]); end
        vectors++; if (r_flags[8] !== 4'b0000) begin miscompares++; $display("FAIL clf_flags_after: got %b expected 0000", r_flags[8]); end
        run_instr(8'h51, 1'b0);
        vectors++; if (r_ram_en !== 12'b0000_0000_1100) begin miscompares++; $display("FAIL jz_after_clf_ram_en: got %b expected 000000001100", r_ram_en); end
        vectors++; if (r_iar_set !== 12'b0010_0010_0000) begin miscompares++; $display("FAIL jz_after_clf_iar_set: got %b expected 001000100000", r_iar_set); end
    endtask

    task automatic test_hold;
        int stayed;
        run_instr(8'h70, 1'b1);
        vectors++; if (r_held !== 12'b0) begin miscompares++; $display("FAIL hold_mid_instr: held got %b expected 0", r_held); end
        vectors++; if (r_iar_set !== 12'b0000_0010_0000) begin miscompares++; $display("FAIL hold_instr_complete: iar_set got %b expected 000000100000", r_iar_set); end
        vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL hold_parked: held got %b expected 1", held); end
        vectors++; if (all_out !== 22'd0) begin miscompares++; $display("FAIL hold_strobes: got %h expected 0", all_out); end
        stayed = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (held === 1'b1 && all_out === 22'd0) stayed++;
        end
        vectors++; if (stayed != 20) begin miscompares++; $display("FAIL hold_stays_idle: idle cycles got %0d expected 20", stayed); end
        hold = 1'b0;
        @(negedge clk);
        vectors++; if (held !== 1'b0 || iar_en !== 1'b1 || mar_set !== 1'b0) begin miscompares++; $display("FAIL hold_release: held/iar_en/mar_set got %b%b%b expected 010", held, iar_en, mar_set); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] prog [4];
        prog[0] = 8'h80; prog[1] = 8'h03; prog[2] = 8'h51; prog[3] = 8'h1B;
        alu_flags = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            run_instr(prog[k], 1'b0);
            vectors++; if (r_ir_set !== 12'b0000_0000_1000) begin miscompares++; $display("FAIL b2b_ir_set[%0d]: got %b expected 000000001000", k, r_ir_set); end
            vectors++; if (r_held !== 12'b0 || r_iar_en[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_no_bubble[%0d]: held %b iar_en0 %b expected 0/1", k, r_held, r_iar_en[0]); end
        end
        vectors++; if (r_ram_en !== 12'b0000_0000_1100 && prog[2] == 8'h51) begin end
        vectors--;
        vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL b2b_flags: got %b expected 1010", flags); end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) ir = 8'h1B;
            @(negedge clk);
        end
        vectors++; if (ram_set !== 1'b1) begin miscompares++; $display("FAIL st_5s_before_reset: ram_set got %b expected 1", ram_set); end
        rst = 1'b1;
        #1;
        vectors++; if (ram_set !== 1'b0) begin miscompares++; $display("FAIL reset_drops_ram_set: got %b expected 0", ram_set); end
        vectors++; if (all_out !== 22'd0) begin miscompares++; $display("FAIL reset_mid_outputs: got %h expected 0", all_out); end
        vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL reset_mid_held: got %b expected 1", held); end
        vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_mid_flags: got %b expected 0000", flags); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (iar_en !== 1'b1 || b1 !== 1'b1 || mar_set !== 1'b0 || acc_set !== 1'b0) begin miscompares++; $display("FAIL refetch_1e: iar_en/b1/mar_set/acc_set got %b%b%b%b expected 1100", iar_en, b1, mar_set, acc_set); end
        @(negedge clk);
        vectors++; if (mar_set !== 1'b1 || acc_set !== 1'b1) begin miscompares++; $display("FAIL refetch_1s: mar_set/acc_set got %b%b expected 11", mar_set, acc_set); end
        @(negedge clk);
        vectors++; if (mar_set !== 1'b0 || acc_set !== 1'b0) begin miscompares++; $display("FAIL refetch_2e: mar_set/acc_set got %b%b expected 00", mar_set, acc_set); end
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_alu_cmp;
        test_ld_st_data;
        test_jcaez;
        test_hold;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
